// File: rtl/sim_ram_req_adapter.sv
// Request/response front end for the fixed-latency simulation RAM: tag pipeline, write-hazard stall, response FIFO.
// Optional `SIM_RAM_ADAPTER_STATS_EN adds read/write/stall counters.
module sim_ram_req_adapter #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int READ_DELAY  = 2,
   parameter int WRITE_DELAY = 2,
   parameter int RESP_DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_write,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [ADDR_WIDTH-1:0]   ram_raddr,
   output logic [ADDR_WIDTH-1:0]   ram_waddr,
   output logic [DATA_WIDTH/8-1:0] ram_wstrb,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
`ifdef SIM_RAM_ADAPTER_STATS_EN
   output logic [31:0]             stat_reads,
   output logic [31:0]             stat_writes,
   output logic [31:0]             stat_stalls,
`endif
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);

   localparam int IW = ADDR_WIDTH - 2;
   localparam int PW = $clog2(RESP_DEPTH);
   localparam int CW = $clog2(RESP_DEPTH + READ_DELAY + 1) + 1;

   logic                   fire;
   logic                   hazard;
   logic                   credit_ok;
   logic [CW-1:0]          inflight;
   logic [CW-1:0]          used;
   logic [READ_DELAY-1:0]  tag_vld_q, tag_vld_d;
   logic [READ_DELAY-1:0]  tag_wr_q, tag_wr_d;
   logic [WRITE_DELAY-1:0] wtrk_vld_q, wtrk_vld_d;
   logic [IW-1:0]          wtrk_idx_q [WRITE_DELAY];
   logic [IW-1:0]          wtrk_idx_d [WRITE_DELAY];
   logic [DATA_WIDTH-1:0]  fifo_data_q [RESP_DEPTH];
   logic [RESP_DEPTH-1:0]  fifo_wr_q;
   logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
   logic [PW:0]            cnt_q, cnt_d;
   logic                   push, pop;

   assign ram_raddr = req_addr;
   assign ram_waddr = req_addr;
   assign ram_wdata = req_wdata;
   assign ram_wstrb = (fire && req_write) ? req_wstrb : '0;

   always_comb begin
      hazard   = 1'b0;
      inflight = '0;
      for (int i = 0; i < WRITE_DELAY; i++) begin
         if (wtrk_vld_q[i] && (wtrk_idx_q[i] == req_addr[ADDR_WIDTH-1:2])) hazard = 1'b1;
      end
      for (int i = 0; i < READ_DELAY; i++) begin
         inflight = inflight + CW'(tag_vld_q[i]);
      end
      // Credit uses last cycle's count; a pop this cycle is not reused until next cycle.
      used      = CW'(cnt_q) + inflight;
      credit_ok = (used < CW'(RESP_DEPTH));
      req_ready = !reset && credit_ok && !(req_valid && !req_write && hazard);
      fire      = req_valid && req_ready;
   end

   always_comb begin
      tag_vld_d     = tag_vld_q << 1;
      tag_vld_d[0]  = fire;
      tag_wr_d      = tag_wr_q << 1;
      tag_wr_d[0]   = req_write;
      wtrk_vld_d    = wtrk_vld_q << 1;
      wtrk_vld_d[0] = fire && req_write;
      wtrk_idx_d[0] = req_addr[ADDR_WIDTH-1:2];
      for (int i = 1; i < WRITE_DELAY; i++) begin
         wtrk_idx_d[i] = wtrk_idx_q[i-1];
      end
   end

   assign push       = tag_vld_q[READ_DELAY-1];
   assign resp_valid = (cnt_q != '0);
   assign pop        = resp_valid && resp_ready;
   assign resp_write = fifo_wr_q[rptr_q];
   assign resp_rdata = fifo_data_q[rptr_q];

   always_comb begin
      wptr_d = push ? wptr_q + PW'(1) : wptr_q;
      rptr_d = pop ? rptr_q + PW'(1) : rptr_q;
      cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         tag_vld_q  <= '0;
         wtrk_vld_q <= '0;
         wptr_q     <= '0;
         rptr_q     <= '0;
         cnt_q      <= '0;
      end else begin
         tag_vld_q  <= tag_vld_d;
         wtrk_vld_q <= wtrk_vld_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // Payload registers carry no reset; the valid bits above qualify them.
   always_ff @(posedge clock) begin
      tag_wr_q   <= tag_wr_d;
      wtrk_idx_q <= wtrk_idx_d;
      if (push) begin
         fifo_data_q[wptr_q] <= tag_wr_q[READ_DELAY-1] ? '0 : ram_rdata;
         fifo_wr_q[wptr_q]   <= tag_wr_q[READ_DELAY-1];
      end
   end

`ifdef SIM_RAM_ADAPTER_STATS_EN
   logic [31:0] stat_reads_q, stat_writes_q, stat_stalls_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         stat_reads_q  <= '0;
         stat_writes_q <= '0;
         stat_stalls_q <= '0;
      end else begin
         if (fire && !req_write)     stat_reads_q  <= stat_reads_q + 32'd1;
         if (fire && req_write)      stat_writes_q <= stat_writes_q + 32'd1;
         if (req_valid && !req_ready) stat_stalls_q <= stat_stalls_q + 32'd1;
      end
   end

   assign stat_reads  = stat_reads_q;
   assign stat_writes = stat_writes_q;
   assign stat_stalls = stat_stalls_q;
`endif

endmodule
